// File: rtl/wb_master_seq.sv
// wb_master_seq - Wishbone classic single-transfer initiator with valid/ready command and response.
// Optional bus timeout abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_seq #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_we_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state, state_n;
  logic                  cmd_ready_n;
  logic                  cyc_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [SEL_WIDTH-1:0]  sel_n;
  logic                  rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_data_n;
  logic                  rsp_err_n;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort when this cycle's increment would make the count reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rsp_timeout_n;
`endif

  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready_o;
    cyc_n       = wb_cyc_o;
    we_n        = wb_we_o;
    addr_n      = wb_addr_o;
    data_n      = wb_data_o;
    sel_n       = wb_sel_o;
    rsp_valid_n = rsp_valid_o;
    rsp_data_n  = rsp_data_o;
    rsp_err_n   = rsp_err_o;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_n         = cnt;
    rsp_timeout_n = rsp_timeout_o;
`endif
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_ready_o && cmd_valid_i) begin
          cmd_ready_n = 1'b0;
          cyc_n       = 1'b1;
          we_n        = cmd_we_i;
          addr_n      = cmd_addr_i;
          data_n      = cmd_data_i;
          sel_n       = cmd_sel_i;
          state_n     = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_n       = '0;
`endif
        end
      end
      BUS: begin
        if (wb_ack_i || wb_err_i) begin
          cyc_n       = 1'b0;
          we_n        = 1'b0;
          data_n      = '0;
          sel_n       = '0;
          rsp_valid_n = 1'b1;
          // Error wins over a simultaneous ack, so data only passes on a clean read ack.
          rsp_data_n  = (!wb_we_o && !wb_err_i) ? wb_data_i : '0;
          rsp_err_n   = wb_err_i;
          state_n     = RESP;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_timeout_n = 1'b0;
        end else if (cnt == CNT_LAST) begin
          cyc_n         = 1'b0;
          we_n          = 1'b0;
          data_n        = '0;
          sel_n         = '0;
          rsp_valid_n   = 1'b1;
          rsp_data_n    = '0;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
          state_n       = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_n = 1'b0;
          rsp_data_n  = '0;
          rsp_err_n   = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_timeout_n = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_ready_o <= cmd_ready_n;
      wb_cyc_o    <= cyc_n;
      wb_stb_o    <= cyc_n;
      wb_we_o     <= we_n;
      wb_addr_o   <= addr_n;
      wb_data_o   <= data_n;
      wb_sel_o    <= sel_n;
      rsp_valid_o <= rsp_valid_n;
      rsp_data_o  <= rsp_data_n;
      rsp_err_o   <= rsp_err_n;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt           <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      rsp_timeout_o <= rsp_timeout_n;
    end
  end
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule
